mul_add_nbym: RTL

Sequential shift-add multiply-accumulate unit computing Product = Multiplicand × Multiplier + Addend for 8-bit unsigned operands into a 16-bit result. It is the inverse companion of the 16/8 sequential divider. Feeding it a divider's Divisor, Quotient and Remainder reconstructs the original Dividend, which lets the datapath self-check divider results. It uses the same St/Ready start-and-wait handshake as the divider, so a single controller can drive both.

---
 rtl/mul_add_pkg.sv | 11 +
 rtl/mul_add_nbym_if.sv | 16 +
 rtl/mul_add_datapath.sv | 71 +++++++
 rtl/mul_add_nbym.sv | 76 +++++++
 4 files changed

// File: rtl/mul_add_pkg.sv
// Shared constants and state type for the sequential multiply-add unit.
package mul_add_pkg;
    localparam int unsigned MW = 8;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned CW = $clog2(MW + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;
endpackage

// File: rtl/mul_add_nbym_if.sv
// Start/Ready handshake bundle for mul_add_nbym.
interface mul_add_nbym_if;
    import mul_add_pkg::*;

    logic          St;
    logic [MW-1:0] Multiplicand_in;
    logic [MW-1:0] Multiplier_in;
    logic [MW-1:0] Addend_in;
    logic          Ready;
    logic [PW-1:0] Product;

    modport master (output St, Multiplicand_in, Multiplier_in, Addend_in,
                    input  Ready, Product);
    modport slave  (input  St, Multiplicand_in, Multiplier_in, Addend_in,
                    output Ready, Product);
endinterface

// File: rtl/mul_add_datapath.sv
// A/Q/M registers with add-and-shift step; MUL_EARLY_EXIT_EN adds a barrel
// shift that finishes once no multiplier bits remain to be consumed.
module mul_add_datapath
    import mul_add_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_c,
    input  logic          step_c,
    input  logic [MW-1:0] mcand,
    input  logic [MW-1:0] mplier,
    input  logic [MW-1:0] addend,
    input  logic [CW-1:0] cnt,
    output logic          last_c,
    output logic [PW-1:0] product_c
);
    logic [MW:0]   a_q, a_d;
    logic [MW-1:0] q_q, q_d;
    logic [MW-1:0] m_q, m_d;
    logic [MW:0]   sum_c;
    logic [2*MW:0] shift_c;

    // One add-and-shift step; the adder carry lands in the top bit of A
    always_comb begin
        sum_c   = a_q + (q_q[0] ? {1'b0, m_q} : '0);
        shift_c = {sum_c, q_q} >> 1;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        if (load_c) begin
            a_d = {1'b0, addend};
            q_d = mplier;
            m_d = mcand;
        end else if (step_c) begin
            a_d = shift_c[2*MW:MW];
            q_d = shift_c[MW-1:0];
        end
    end

`ifdef MUL_EARLY_EXIT_EN
    logic [CW-1:0] rem_c;
    logic [MW-1:0] mask_c;

    // rem_c = multiplier bits still unconsumed after this step
    always_comb begin
        rem_c = CW'(MW - 1) - cnt;
        for (int unsigned i = 0; i < MW; i++) begin
            mask_c[i] = (CW'(i) < rem_c);
        end
        last_c    = (((q_q >> 1) & mask_c) == '0);
        product_c = PW'(shift_c >> rem_c);
    end
`else
    always_comb begin
        last_c    = (cnt == CW'(MW - 1));
        product_c = PW'(shift_c);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            q_q <= '0;
            m_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            m_q <= m_d;
        end
    end
endmodule

// File: rtl/mul_add_nbym.sv
// Sequential Product = Multiplicand * Multiplier + Addend with St/Ready handshake.
// Optional MUL_EARLY_EXIT_EN shortens latency for small multipliers.
module mul_add_nbym
    import mul_add_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mul_add_nbym_if.slave  bus
);
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic [PW-1:0] product_q, product_d;
    logic          load_c, step_c, last_c;
    logic [PW-1:0] step_product_c;

    mul_add_datapath u_dp (
        .clk       (clk),
        .rst       (rst),
        .load_c    (load_c),
        .step_c    (step_c),
        .mcand     (bus.Multiplicand_in),
        .mplier    (bus.Multiplier_in),
        .addend    (bus.Addend_in),
        .cnt       (cnt_q),
        .last_c    (last_c),
        .product_c (step_product_c)
    );

    // Start only from IDLE; St during CALC (including the final edge) is ignored
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        product_d = product_q;
        load_c    = 1'b0;
        step_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.St) begin
                    load_c  = 1'b1;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step_c = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (last_c) begin
                    product_d = step_product_c;
                    ready_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            product_q <= product_d;
        end
    end

    assign bus.Ready   = ready_q;
    assign bus.Product = product_q;
endmodule
